mips_multi_cycle_controller: RTL and testbench

MIPS_MULTI_CYCLE_CONTROLLER -- requirements
Module: mips_multi_cycle_controller

---
 rtl/mips_multi_cycle_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_mips_multi_cycle_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi_cycle_controller.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences fetch/decode/execute/writeback
// and counts retired instructions, with an optional memory-ready handshake.
`timescale 1ns/1ps
module mips_multi_cycle_controller #(
    parameter int unsigned CNT_W         = 16,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Func,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PcWrite,
    output logic             RegWrite,
    output logic             AluSrcA,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Halted,
    output logic [1:0]       PcSrc,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemToReg,
    output logic [1:0]       AluSrcB,
    output logic [2:0]       AluOperation,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_IEXEC  = 4'd10;
    localparam logic [3:0] S_IWB    = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_JR     = 4'd13;
    localparam logic [3:0] S_HALT   = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy;
    logic             retire;

    assign rdy        = MEM_HANDSHAKE ? MemReady : 1'b1;
    assign State      = state_q;
    assign InstrCount = cnt_q;

    // State and retired-instruction counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and retire decision
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (OpCode)
                    OP_RTYPE:        state_d = (Func == FN_JR) ? S_JR : S_EXEC;
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_JAL:          state_d = S_JAL;
                    OP_HALT:         state_d = S_HALT;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (rdy) state_d = S_MEMWB;
            S_MEMWR: begin
                if (rdy) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Moore output decode; FETCH strobes are gated by reset since reset parks the FSM there
    always_comb begin
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PcWrite      = 1'b0;
        RegWrite     = 1'b0;
        AluSrcA      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Halted       = 1'b0;
        PcSrc        = 2'b00;
        RegDst       = 2'b00;
        MemToReg     = 2'b00;
        AluSrcB      = 2'b00;
        AluOperation = 3'b000;
        case (state_q)
            S_FETCH: begin
                MemRead      = 1'b1;
                AluSrcB      = 2'b01;
                AluOperation = ALU_ADD;
                IRWrite      = rdy & rst;
                PcWrite      = rdy & rst;
            end
            S_DECODE: begin
                AluSrcB      = 2'b11;
                AluOperation = ALU_ADD;
            end
            S_MEMADR: begin
                AluSrcA      = 1'b1;
                AluSrcB      = 2'b10;
                AluOperation = ALU_ADD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 2'b01;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                AluSrcA = 1'b1;
                case (Func)
                    FN_ADD:  AluOperation = ALU_ADD;
                    FN_SUB:  AluOperation = ALU_SUB;
                    FN_AND:  AluOperation = ALU_AND;
                    FN_OR:   AluOperation = ALU_OR;
                    FN_SLT:  AluOperation = ALU_SLT;
                    default: AluOperation = ALU_ADD;
                endcase
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_IEXEC: begin
                AluSrcA      = 1'b1;
                AluSrcB      = 2'b10;
                AluOperation = (OpCode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_IWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                AluSrcA      = 1'b1;
                AluOperation = ALU_SUB;
                PcSrc        = 2'b01;
                PcWrite      = (OpCode == OP_BEQ) ? Zero : ~Zero;
            end
            S_JUMP: begin
                PcSrc   = 2'b10;
                PcWrite = 1'b1;
            end
            S_JAL: begin
                PcSrc    = 2'b10;
                PcWrite  = 1'b1;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemToReg = 2'b10;
            end
            S_JR: begin
                PcSrc   = 2'b11;
                PcWrite = 1'b1;
            end
            S_HALT:   Halted = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_mips_multi_cycle_controller.sv
// Scoreboard bench for mips_multi_cycle_controller: directed instruction sequences push
// expected per-cycle state/controls/count; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mips_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OpCode, Func;
    logic       Zero, MemReady;

    logic        a_iord, a_irw, a_pcw, a_regw, a_srca, a_memr, a_memw, a_halt;
    logic [1:0]  a_pcsrc, a_regdst, a_m2r, a_srcb;
    logic [2:0]  a_alu;
    logic [3:0]  a_state;
    logic [15:0] a_cnt;

    logic        b_iord, b_irw, b_pcw, b_regw, b_srca, b_memr, b_memw, b_halt;
    logic [1:0]  b_pcsrc, b_regdst, b_m2r, b_srcb;
    logic [2:0]  b_alu;
    logic [3:0]  b_state;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    mips_multi_cycle_controller dut_a (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Func(Func), .Zero(Zero), .MemReady(MemReady),
        .IorD(a_iord), .IRWrite(a_irw), .PcWrite(a_pcw), .RegWrite(a_regw), .AluSrcA(a_srca),
        .MemRead(a_memr), .MemWrite(a_memw), .Halted(a_halt), .PcSrc(a_pcsrc), .RegDst(a_regdst),
        .MemToReg(a_m2r), .AluSrcB(a_srcb), .AluOperation(a_alu), .State(a_state),
        .InstrCount(a_cnt)
    );

    mips_multi_cycle_controller #(.CNT_W(4), .MEM_HANDSHAKE(1'b1)) dut_b (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Func(Func), .Zero(Zero), .MemReady(MemReady),
        .IorD(b_iord), .IRWrite(b_irw), .PcWrite(b_pcw), .RegWrite(b_regw), .AluSrcA(b_srca),
        .MemRead(b_memr), .MemWrite(b_memw), .Halted(b_halt), .PcSrc(b_pcsrc), .RegDst(b_regdst),
        .MemToReg(b_m2r), .AluSrcB(b_srcb), .AluOperation(b_alu), .State(b_state),
        .InstrCount(b_cnt)
    );

    logic [18:0] a_outs, b_outs;
    assign a_outs = {a_iord, a_irw, a_pcw, a_regw, a_srca, a_memr, a_memw, a_halt,
                     a_pcsrc, a_regdst, a_m2r, a_srcb, a_alu};
    assign b_outs = {b_iord, b_irw, b_pcw, b_regw, b_srca, b_memr, b_memw, b_halt,
                     b_pcsrc, b_regdst, b_m2r, b_srcb, b_alu};

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [18:0] outs;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;

    // Control-table reference: {IorD,IRWrite,PcWrite,RegWrite,AluSrcA,MemRead,MemWrite,Halted,
    // PcSrc,RegDst,MemToReg,AluSrcB,AluOperation}
    function automatic logic [18:0] spec_out(input logic [3:0] st, input logic rstv,
                                             input logic rdyv, input logic z,
                                             input logic [5:0] op, input logic [5:0] fn);
        logic [18:0] o;
        o = '0;
        case (st)
            4'd0:  o = {1'b0, rdyv & rstv, rdyv & rstv, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b010};
            4'd1:  o = {8'b00000000, 2'b00, 2'b00, 2'b00, 2'b11, 3'b010};
            4'd2:  o = {8'b00001000, 2'b00, 2'b00, 2'b00, 2'b10, 3'b010};
            4'd3:  o = {8'b10000100, 8'b0, 3'b000};
            4'd4:  o = {8'b00010000, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000};
            4'd5:  o = {8'b10000010, 8'b0, 3'b000};
            4'd6: begin
                o = {8'b00001000, 8'b0, 3'b010};
                if (fn == 6'b100010) o[2:0] = 3'b110;
                if (fn == 6'b100100) o[2:0] = 3'b000;
                if (fn == 6'b100101) o[2:0] = 3'b001;
                if (fn == 6'b101010) o[2:0] = 3'b111;
            end
            4'd7:  o = {8'b00010000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000};
            4'd8:  o = {2'b00, (op == 6'b000100) ? z : ~z, 5'b01000, 2'b01, 6'b0, 3'b110};
            4'd9:  o = {8'b00100000, 2'b10, 6'b0, 3'b000};
            4'd10: o = {8'b00001000, 6'b0, 2'b10, (op == 6'b001010) ? 3'b111 : 3'b010};
            4'd11: o = {8'b00010000, 8'b0, 3'b000};
            4'd12: o = {8'b00110000, 2'b10, 2'b10, 2'b10, 2'b00, 3'b000};
            4'd13: o = {8'b00100000, 2'b11, 6'b0, 3'b000};
            4'd14: o = {8'b00000001, 8'b0, 3'b000};
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic logic [3:0] hexc(input logic [7:0] c);
        return (c >= 8'h61) ? 4'(c - 8'd87) : 4'(c - 8'd48);
    endfunction

    // Push the expectation for the current cycle, then advance to just after the next edge
    task automatic step(input string tag, input logic [3:0] st);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.outs = spec_out(st, rst, MemReady, Zero, OpCode, Func);
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input string seq, input string rd, input bit counted);
        OpCode = op;
        Func   = fn;
        Zero   = z;
        for (int i = 0; i < seq.len(); i++) begin
            MemReady = (rd[i] == 8'h31);
            step(tag, hexc(seq[i]));
        end
        if (counted) exp_cnt++;
    endtask

    // Monitor: every cycle that has an expectation queued is compared on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (a_state !== mon_e.st) begin
                n_bad++;
                $display("FAIL %s state: got %0d expected %0d", mon_e.tag, a_state, mon_e.st);
            end
            n_cmp++;
            if (a_outs !== mon_e.outs) begin
                n_bad++;
                $display("FAIL %s controls (st %0d): got %b expected %b", mon_e.tag, mon_e.st, a_outs, mon_e.outs);
            end
            n_cmp++;
            if (a_cnt !== 16'(mon_e.cnt)) begin
                n_bad++;
                $display("FAIL %s InstrCount: got %0d expected %0d", mon_e.tag, a_cnt, 16'(mon_e.cnt));
            end
            n_cmp++;
            if (b_state !== mon_e.st) begin
                n_bad++;
                $display("FAIL %s state_w4: got %0d expected %0d", mon_e.tag, b_state, mon_e.st);
            end
            n_cmp++;
            if (b_outs !== mon_e.outs) begin
                n_bad++;
                $display("FAIL %s controls_w4 (st %0d): got %b expected %b", mon_e.tag, mon_e.st, b_outs, mon_e.outs);
            end
            n_cmp++;
            if (b_cnt !== 4'(mon_e.cnt)) begin
                n_bad++;
                $display("FAIL %s InstrCount_w4: got %0d expected %0d", mon_e.tag, b_cnt, 4'(mon_e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; OpCode = '0; Func = '0; Zero = 1'b0; MemReady = 1'b1;
        @(posedge clk);
        #1;
        step("reset", 4'd0);
        step("reset", 4'd0);
        rst = 1'b1;

        run("add",    6'b000000, 6'b100000, 1'b0, "0167", "1111", 1'b1);
        run("lw_wait",6'b100011, 6'b000000, 1'b0, "01233334", "11100011", 1'b1);
        run("sw_stall",6'b101011,6'b000000, 1'b0, "001255", "011101", 1'b1);
        run("sub",    6'b000000, 6'b100010, 1'b0, "0167", "1111", 1'b1);
        run("and",    6'b000000, 6'b100100, 1'b0, "0167", "1111", 1'b1);
        run("or",     6'b000000, 6'b100101, 1'b0, "0167", "1111", 1'b1);
        run("slt",    6'b000000, 6'b101010, 1'b0, "0167", "1111", 1'b1);
        run("r_dflt", 6'b000000, 6'b000011, 1'b0, "0167", "1111", 1'b1);
        run("beq_z0", 6'b000100, 6'b000000, 1'b0, "018", "111", 1'b1);
        run("beq_z1", 6'b000100, 6'b000000, 1'b1, "018", "111", 1'b1);
        run("bne_z0", 6'b000101, 6'b000000, 1'b0, "018", "111", 1'b1);
        run("bne_z1", 6'b000101, 6'b000000, 1'b1, "018", "111", 1'b1);
        run("addi",   6'b001000, 6'b000000, 1'b0, "01ab", "1111", 1'b1);
        run("slti",   6'b001010, 6'b000000, 1'b0, "01ab", "1111", 1'b1);
        run("j",      6'b000010, 6'b000000, 1'b0, "019", "111", 1'b1);
        run("jal",    6'b000011, 6'b000000, 1'b0, "01c", "111", 1'b1);
        run("jr",     6'b000000, 6'b001000, 1'b0, "01d", "111", 1'b1);
        run("nop",    6'b000001, 6'b000000, 1'b0, "01", "11", 1'b0);

        run("halt",   6'b111111, 6'b000000, 1'b0, "01e", "111", 1'b0);
        for (int i = 0; i < 49; i++) begin
            MemReady = 1'($urandom_range(0, 1));
            Zero     = 1'($urandom_range(0, 1));
            step("halt_hold", 4'd14);
        end
        rst = 1'b0;
        exp_cnt = 0;
        step("halt_rst", 4'd0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++)
            run("addi16", 6'b001000, 6'b000000, 1'b0, "01ab", "1111", 1'b1);
        run("sw_rst", 6'b101011, 6'b000000, 1'b0, "0125", "1110", 1'b0);
        rst = 1'b0;
        exp_cnt = 0;
        step("memwr_rst", 4'd0);
        rst = 1'b1;
        run("add_post", 6'b000000, 6'b100000, 1'b0, "0167", "1111", 1'b1);
        step("final", 4'd0);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
